sysbus_apb_bridge: RTL and testbench



---
 rtl/sysbus_pkg.sv | 25 ++
 rtl/sysbus_apb_timeout.sv | 37 +++
 rtl/sysbus_apb_bridge.sv | 163 ++++++++++++++++
 tb/tb_sysbus_apb_bridge.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// Shared types and constants for the debug system-bus to APB bridge.
package sysbus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   typedef enum logic [2:0] {
      OP_PUT_FULL = 3'd0,
      OP_PUT_PART = 3'd1,
      OP_GET      = 3'd4
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == OP_PUT_FULL) || (op == OP_PUT_PART) || (op == OP_GET);
   endfunction

endpackage

// File: rtl/sysbus_apb_timeout.sv
// ACCESS-phase watchdog: counts pready-low cycles and flags the cycle in which
// the count reaches TIMEOUT_CYCLES. Instantiated only with SYSBUS_APB_TIMEOUT_EN.
module sysbus_apb_timeout #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int TO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + TO_CNT_W'(1);
      end
   end

   // Fires in the cycle whose increment would land on TIMEOUT_CYCLES.
   assign expired = inc && (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sysbus_apb_bridge.sv
// Debug system-bus A/D channel to APB bridge, one request in flight at a time.
// Optional ACCESS timeout enabled with `define SYSBUS_APB_TIMEOUT_EN.
module sysbus_apb_bridge
   import sysbus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [2:0]        a_opcode,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [MASK_W-1:0] a_mask,
   input  logic [DATA_W-1:0] a_data,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [DATA_W-1:0] d_data,
   output logic              d_error,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [MASK_W-1:0] pstrb,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pslverr
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 2..65535");
   end

   state_e            state_q, state_d;
   logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d, d_data_q, d_data_d;
   logic [MASK_W-1:0] pstrb_q, pstrb_d;
   logic              d_valid_q, d_valid_d, d_error_q, d_error_d;
   logic              to_expired;

`ifdef SYSBUS_APB_TIMEOUT_EN
   sysbus_apb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q == SETUP),
      .inc    ((state_q == ACCESS) && !pready),
      .expired(to_expired)
   );
`else
   assign to_expired = 1'b0;
`endif

   assign a_ready = (state_q == IDLE);

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      d_valid_d = d_valid_q;
      d_data_d  = d_data_q;
      d_error_d = d_error_q;
      case (state_q)
         IDLE: begin
            // Request fields are captured straight into the APB output flops.
            if (a_valid) begin
               if (op_legal(a_opcode) && (a_address[1:0] == 2'b00)) begin
                  state_d  = SETUP;
                  psel_d   = 1'b1;
                  paddr_d  = a_address;
                  pwrite_d = (a_opcode != OP_GET);
                  pwdata_d = a_data;
                  case (a_opcode)
                     OP_PUT_FULL: pstrb_d = '1;
                     OP_PUT_PART: pstrb_d = a_mask;
                     default:     pstrb_d = '0;
                  endcase
               end else begin
                  state_d   = RESP;
                  d_valid_d = 1'b1;
                  d_error_d = 1'b1;
                  d_data_d  = '0;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            // pready wins over a timeout landing in the same cycle.
            if (pready) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               d_valid_d = 1'b1;
               d_data_d  = pwrite_q ? '0 : prdata;
               d_error_d = pslverr;
            end else if (to_expired) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               d_valid_d = 1'b1;
               d_data_d  = '0;
               d_error_d = 1'b1;
            end
         end
         RESP: begin
            if (d_ready) begin
               state_d   = IDLE;
               d_valid_d = 1'b0;
               d_data_d  = '0;
               d_error_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         d_valid_q <= 1'b0;
         d_data_q  <= '0;
         d_error_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         d_valid_q <= d_valid_d;
         d_data_q  <= d_data_d;
         d_error_q <= d_error_d;
      end
   end

   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;
   assign pstrb   = pstrb_q;
   assign d_valid = d_valid_q;
   assign d_data  = d_data_q;
   assign d_error = d_error_q;

endmodule

// File: tb/tb_sysbus_apb_bridge.sv
// Bench for sysbus_apb_bridge: directed cases plus random requests checked
// against a memory-level reference model and an APB slave model.
module tb_sysbus_apb_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid, a_ready, d_valid, d_ready, d_error;
   logic [2:0]  a_opcode;
   logic [31:0] a_address, a_data, d_data, paddr, pwdata, prdata;
   logic [3:0]  a_mask, pstrb;
   logic        psel, penable, pwrite, pready, pslverr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] slv_mem[logic [31:0]];
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   sysbus_apb_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
      .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_error(d_error),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
      .pslverr(pslverr)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] slv_rd(input logic [31:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Slave answers with an error for any address in the 0x...F00 page.
   function automatic logic err_page(input logic [31:0] a);
      return a[11:8] == 4'hF;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input int waits, input int dr_delay);
      logic        legal, wr, err;
      logic [3:0]  strb;
      logic [70:0] bus_exp;
      logic [32:0] rsp;
      legal = ((op == 3'd0) || (op == 3'd1) || (op == 3'd4)) && (addr[1:0] == 2'b00);
      wr    = (op != 3'd4);
      strb  = (op == 3'd4) ? 4'h0 : ((op == 3'd0) ? 4'hF : mask);
      err   = !legal || err_page(addr);
      exp_q.push_back({err, (legal && !wr && !err) ? ref_rd(addr) : 32'h0});
      if (legal && wr && !err) ref_mem[addr] = merge(ref_rd(addr), data, strb);

      check_eq("a_ready_idle", 128'(a_ready), 128'(1'b1));
      a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
      tick();
      a_valid = 1'b0; a_opcode = 3'($urandom); a_address = $urandom;
      a_mask = 4'($urandom); a_data = $urandom;
      if (legal) begin
         bus_exp = {1'b1, 1'b0, wr, addr, data, strb};
         check_eq("setup_bus", 128'({psel, penable, pwrite, paddr, pwdata, pstrb}), 128'(bus_exp));
         tick();
         bus_exp[69] = 1'b1;
         for (int c = 0; c <= waits; c++) begin
            check_eq("access_bus", 128'({psel, penable, pwrite, paddr, pwdata, pstrb}), 128'(bus_exp));
            check_eq("access_no_dvalid", 128'(d_valid), 128'(1'b0));
            if (c == waits) begin
               pready  = 1'b1;
               pslverr = err_page(paddr);
               prdata  = pslverr ? 32'h0 : slv_rd(paddr);
               if (!pslverr && pwrite) slv_mem[paddr] = merge(slv_rd(paddr), pwdata, pstrb);
            end else begin
               pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
            end
            tick();
         end
         pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end
      rsp = exp_q.pop_front();
      for (int k = 0; k <= dr_delay; k++) begin
         check_eq("resp", 128'({d_valid, d_error, d_data, a_ready, psel, penable}),
                  128'({1'b1, rsp, 3'b000}));
         if (k == dr_delay) d_ready = 1'b1;
         tick();
      end
      d_ready = 1'b0;
      check_eq("post_handshake", 128'({d_valid, a_ready}), 128'(2'b01));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  bad_ops[5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
      logic [2:0]  op;
      logic [31:0] addr;
      int          acc;

      rst_n = 1'b0; a_valid = 1'b0; a_opcode = 3'd0; a_address = '0; a_mask = '0;
      a_data = '0; d_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
      #12;
      check_eq("reset_outputs",
               128'({a_ready, d_valid, d_error, psel, penable, pwrite, paddr, pwdata, pstrb, d_data}),
               128'({1'b1, 5'b0, 32'h0, 32'h0, 4'h0, 32'h0}));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      slv_mem[32'h1000_0000] = 32'hCAFE_F00D;
      ref_mem[32'h1000_0000] = 32'hCAFE_F00D;
      run_txn(3'd4, 32'h1000_0000, 4'h0, 32'h0, 0, 0);
      run_txn(3'd1, 32'h2000_0004, 4'b0110, 32'h1122_3344, 5, 0);
      run_txn(3'd4, 32'h2000_0004, 4'h0, 32'h0, 1, 1);
      run_txn(3'd4, 32'h0000_0003, 4'h0, 32'h0, 0, 0);
      run_txn(3'd2, 32'h1000_0000, 4'hF, 32'h5555_AAAA, 0, 2);
      run_txn(3'd4, 32'h1000_0F00, 4'h0, 32'h0, 0, 10);
      run_txn(3'd1, 32'h1000_0008, 4'h0, 32'hDEAD_BEEF, 0, 0);
      run_txn(3'd0, 32'h1000_000C, 4'h3, 32'h0BAD_F00D, 2, 0);
      run_txn(3'd4, 32'h1000_000C, 4'h0, 32'h0, 0, 0);

      // Reset pulse during ACCESS discards the request.
      a_valid = 1'b1; a_opcode = 3'd4; a_address = 32'h1000_0008;
      tick();
      a_valid = 1'b0;
      tick();
      check_eq("rst_pre_access", 128'({psel, penable}), 128'(2'b11));
      #2 rst_n = 1'b0;
      #1 check_eq("rst_async_drop", 128'({psel, penable, d_valid}), 128'(3'b000));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("rst_idle", 128'({a_ready, d_valid, psel}), 128'(3'b100));
         tick();
      end
      run_txn(3'd4, 32'h1000_000C, 4'h0, 32'h0, 0, 0);

`ifdef SYSBUS_APB_TIMEOUT_EN
      a_valid = 1'b1; a_opcode = 3'd4; a_address = 32'h1000_0010;
      tick();
      a_valid = 1'b0;
      tick();
      acc = 0;
      while (penable && acc < 20) begin
         pready = 1'b0;
         acc++;
         tick();
      end
      check_eq("timeout_access_len", 128'(acc), 128'(8));
      for (int i = 0; i < 2; i++) begin
         check_eq("timeout_resp", 128'({d_valid, d_error, d_data, psel, penable}),
                  128'({2'b11, 32'h0, 2'b00}));
         pready = 1'b1; prdata = 32'hFFFF_FFFF;
         tick();
      end
      pready = 1'b0;
      d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
      check_eq("timeout_post", 128'({d_valid, a_ready}), 128'(2'b01));
`else
      acc = 0;
`endif

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: op = 3'd0;
            3, 4, 5: op = 3'd1;
            6, 7, 8: op = 3'd4;
            default: op = bad_ops[$urandom_range(0, 4)];
         endcase
         addr = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 9) == 0) addr = addr | 32'h0000_0F00;
         if ($urandom_range(0, 19) == 0) addr = addr | 32'($urandom_range(1, 3));
         run_txn(op, addr, 4'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
